// File: rtl/ret_addr_stack.sv
// Return-address stack: circular LIFO of call return addresses with a registered
// pop port, combinational top-of-stack peek, occupancy status and sticky error flags.
module ret_addr_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              pop_valid,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d, wp_m1;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              mem_we;
  logic [PW-1:0]     mem_waddr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              ovf_set, unf_set;
  logic              is_full, is_empty;

  assign wp_m1    = wp_q - PTR_ONE;
  assign is_full  = (count_q == CNT_MAX);
  assign is_empty = (count_q == '0);

  always_comb begin
    wp_d        = wp_q;
    count_d     = count_q;
    pop_addr_d  = pop_addr_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wp_q;
    mem_wdata   = push_addr;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;

    unique case ({push, pop})
      2'b10: begin
        // When full, WP already points at the oldest entry, so it is overwritten.
        mem_we    = 1'b1;
        mem_waddr = wp_q;
        wp_d      = wp_q + PTR_ONE;
        if (is_full) ovf_set = 1'b1;
        else         count_d = count_q + CNT_ONE;
      end
      2'b01: begin
        if (!is_empty) begin
          pop_addr_d  = mem_q[wp_m1];
          pop_valid_d = 1'b1;
          wp_d        = wp_m1;
          count_d     = count_q - CNT_ONE;
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        pop_valid_d = 1'b1;
        if (!is_empty) begin
          // Replace the top in place: occupancy and pointer are unchanged.
          pop_addr_d = mem_q[wp_m1];
          mem_we     = 1'b1;
          mem_waddr  = wp_m1;
        end else begin
          pop_addr_d = push_addr;
        end
      end
      default: ;
    endcase

    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_set) overflow_d  = 1'b1;
    if (unf_set) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= '0;
      count_q     <= '0;
      pop_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      count_q     <= count_d;
      pop_addr_q  <= pop_addr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem_q[mem_waddr] <= mem_wdata;
  end

  assign pop_addr  = pop_addr_q;
  assign pop_valid = pop_valid_q;
  assign top       = is_empty ? '0 : mem_q[wp_m1];
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack for the program-counter path.
- On a call, the incremented PC (next sequential address) is pushed. On a return, it is popped and delivered as a registered next-PC candidate to the PC mux.
- This is the consumer/reader end of the incremented-PC value: circular LIFO storage with full/empty status and sticky error flags.

Parameters:
- ADDR_W, 10, width of each stored address (matches PC width).
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous, active-low.
- PUSH  input  1  push PUSH_ADDR this cycle (call).
- PUSH_ADDR  input  ADDR_W  address to store (PC+1 value).
- POP  input  1  pop top entry this cycle (return).
- POP_ADDR  output  ADDR_W  registered popped address.
- POP_VALID  output  1  one-cycle pulse: POP_ADDR updated by a successful pop.
- TOP  output  ADDR_W  combinational peek of current top entry; 0 when empty.
- COUNT  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- OVERFLOW  output  1  sticky: a push occurred while FULL.
- UNDERFLOW  output  1  sticky: a pop occurred while EMPTY without a simultaneous push.
- CLR_ERR  input  1  synchronous clear of OVERFLOW/UNDERFLOW.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Write pointer = 0, COUNT = 0.
  - POP_ADDR = 0, POP_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Storage contents are don't-care.
- Reset deassertion is synchronised externally; the block samples nothing on the first edge while RST_N is low.
- Storage: DEPTH-entry array indexed by a $clog2(DEPTH)-bit write pointer WP (next free slot). Top is entry WP-1, modulo DEPTH.
- Push only (PUSH=1, POP=0):
  - Write PUSH_ADDR at WP; WP <= WP+1, wrapping modulo DEPTH.
  - If COUNT<DEPTH, COUNT <= COUNT+1.
  - If FULL: oldest entry is overwritten (circular), COUNT stays DEPTH, and OVERFLOW <= 1.
- Pop only (PUSH=0, POP=1):
  - If not EMPTY: POP_ADDR <= entry[WP-1], POP_VALID <= 1 next cycle, WP <= WP-1, COUNT <= COUNT-1.
  - If EMPTY: no state change, POP_VALID <= 0, POP_ADDR holds, UNDERFLOW <= 1.
- Push and pop in the same cycle:
  - Not EMPTY: POP_ADDR <= old entry[WP-1]; PUSH_ADDR is written to slot WP-1 (replace top). WP and COUNT are unchanged. POP_VALID <= 1. No OVERFLOW, even if FULL.
  - EMPTY: pass-through. POP_ADDR <= PUSH_ADDR, POP_VALID <= 1. COUNT stays 0, no write, no UNDERFLOW.
- Neither push nor pop: POP_VALID <= 0; everything else holds.
- Latency:
  - Pop data appears on POP_ADDR exactly 1 cycle after the POP edge.
  - TOP reflects a push in the cycle after the push edge.
- Error flags:
  - CLR_ERR clears both flags on the next edge.
  - If CLR_ERR coincides with a new error event, the set wins.
- Arithmetic:
  - Pointers wrap naturally modulo DEPTH.
  - COUNT saturates at DEPTH on push and never goes below 0.
  - No address arithmetic is applied to stored values; data is stored verbatim.
- After overflow, the stack holds the newest DEPTH pushes. Pops return them newest-first, then EMPTY asserts.
- Reset mid-operation: the asynchronous clear takes effect immediately. POP_VALID drops the same instant, even mid-pulse.

Test Plan:
- Reset then idle -> COUNT=0, EMPTY=1, FULL=0, POP_ADDR=0, POP_VALID=0, TOP=0, both flags 0.
- Push 0x005, 0x00A, 0x3FF, then 3 pops -> POP_ADDR sequence 0x3FF, 0x00A, 0x005, each with a one-cycle POP_VALID one cycle after its POP. COUNT ends at 0, EMPTY=1.
- Push 9 values 0x001..0x009 (DEPTH=8) -> FULL=1 after the 8th push and OVERFLOW=1 after the 9th. 8 pops return 0x009..0x002; a 9th pop sets UNDERFLOW=1 with POP_VALID=0 and POP_ADDR holding 0x002.
- Push 0x010, 0x020, then PUSH=1/POP=1 with PUSH_ADDR=0x030 -> POP_ADDR=0x020, COUNT=2, TOP=0x030. Two pops then return 0x030, 0x010.
- EMPTY with PUSH=1/POP=1, PUSH_ADDR=0x155 -> POP_ADDR=0x155, POP_VALID=1, COUNT=0, UNDERFLOW=0.
- Push 4 entries, assert RST_N low mid-cycle during a POP -> outputs clear immediately, COUNT=0. After release, a pop flags UNDERFLOW. CLR_ERR for one cycle -> UNDERFLOW=0.
